// File: rtl/mtr_drv_multi_pkg.sv
// Shared constants and duty arithmetic for the N-channel H-bridge PWM driver.
// Duty values travel as 32-bit words so one helper serves any channel width.
package mtr_drv_pkg;

   localparam int MTR_SPD_W    = 11;
   localparam int MTR_DEADTIME = 4;
   localparam int MTR_SLEW     = 16;

   // 50% duty: the point at which the bridge delivers no net drive.
   function automatic logic [31:0] mid_scale(input int width);
      return 32'(1) << (width - 1);
   endfunction

   function automatic logic [31:0] width_mask(input int width);
      return (32'(1) << width) - 32'(1);
   endfunction

   // One period of movement of the applied duty toward the target. The step
   // never overshoots the target, so the result stays inside [0, 2^width-1].
   function automatic logic [31:0] slew_next(input logic [31:0] app,
                                             input logic [31:0] tgt,
                                             input logic [31:0] step,
                                             input int          width);
      int          diff;
      int          lim;
      logic [31:0] nxt;
      diff = int'(tgt & width_mask(width)) - int'(app & width_mask(width));
      lim  = int'(step);
      if (step == 32'd0 || (diff <= lim && diff >= -lim)) begin
         nxt = tgt;
      end else if (diff > 0) begin
         nxt = app + step;
      end else begin
         nxt = app - step;
      end
      return nxt & width_mask(width);
   endfunction

endpackage

// File: rtl/mtr_drv_multi_if.sv
// Bundle between the motion controller (master) and the motor driver (slave):
// speed commands and enable in, bridge PWM pairs and status out.
interface mtr_drv_multi_if
   import mtr_drv_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int SPD_W  = MTR_SPD_W
);

   logic                    en;
   logic [NUM_CH*SPD_W-1:0] spd;
   logic [NUM_CH-1:0]       pwm_hi;
   logic [NUM_CH-1:0]       pwm_lo;
   logic [NUM_CH-1:0]       at_tgt;
   logic                    prd_start;

   modport master (
      output en,
      output spd,
      input  pwm_hi,
      input  pwm_lo,
      input  at_tgt,
      input  prd_start
   );

   modport slave (
      input  en,
      input  spd,
      output pwm_hi,
      output pwm_lo,
      output at_tgt,
      output prd_start
   );

endinterface

// File: rtl/mtr_drv_multi_pwm_ch.sv
// One bridge channel: applied-duty register with per-period slew, raw compare
// against the shared counter, and deadtime-gated complementary output flops.
module mtr_pwm_ch
   import mtr_drv_pkg::*;
#(
   parameter int SPD_W     = MTR_SPD_W,
   parameter int DEADTIME  = MTR_DEADTIME,
   parameter int SLEW_STEP = MTR_SLEW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SPD_W-1:0] cnt,
   input  logic             wrap,
   input  logic             en,
   input  logic [SPD_W-1:0] spd,
   output logic             pwm_hi,
   output logic             pwm_lo,
   output logic             at_tgt
);

   localparam logic [SPD_W-1:0] MID  = SPD_W'(mid_scale(SPD_W));
   localparam logic [SPD_W:0]   DT_X = (SPD_W + 1)'(DEADTIME);

   logic [SPD_W-1:0] app_q;
   logic [SPD_W-1:0] app_d;
   logic             pwm_hi_q;
   logic             pwm_hi_d;
   logic             pwm_lo_q;
   logic             pwm_lo_d;
   logic             at_tgt_q;
   logic             at_tgt_d;

   logic [SPD_W-1:0] tgt;
   logic             raw;
   logic [SPD_W:0]   lo_start;

   always_comb begin
      // Offset-binary target: inverting the sign bit adds mid-scale without overflow.
      tgt      = spd ^ MID;
      raw      = (cnt < app_q);
      lo_start = {1'b0, app_q} + DT_X;

      app_d = app_q;
      if (wrap) begin
         if (!en) begin
            app_d = MID;
         end else begin
            app_d = SPD_W'(slew_next(32'(app_q), 32'(tgt), 32'(SLEW_STEP), SPD_W));
         end
      end

      // Low side waits DEADTIME after the high side drops; high side waits
      // DEADTIME after cnt=0, which is where the low side drops across the wrap.
      pwm_hi_d = en & raw & ({1'b0, cnt} >= DT_X);
      pwm_lo_d = en & ~raw & ({1'b0, cnt} >= lo_start);
      at_tgt_d = (app_q == tgt);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         app_q    <= MID;
         pwm_hi_q <= 1'b0;
         pwm_lo_q <= 1'b0;
         at_tgt_q <= 1'b0;
      end else begin
         app_q    <= app_d;
         pwm_hi_q <= pwm_hi_d;
         pwm_lo_q <= pwm_lo_d;
         at_tgt_q <= at_tgt_d;
      end
   end

   assign pwm_hi = pwm_hi_q;
   assign pwm_lo = pwm_lo_q;
   assign at_tgt = at_tgt_q;

endmodule

// File: rtl/mtr_drv_multi.sv
// N-channel H-bridge PWM driver: shared free-running period counter and
// period-start pulse, plus one mtr_pwm_ch per motor channel.
module mtr_drv_multi
   import mtr_drv_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int SPD_W     = MTR_SPD_W,
   parameter int DEADTIME  = MTR_DEADTIME,
   parameter int SLEW_STEP = MTR_SLEW
) (
   input  logic            clk,
   input  logic            rst,
   mtr_drv_multi_if.slave  bus
);

   logic [SPD_W-1:0]  cnt_q;
   logic [SPD_W-1:0]  cnt_d;
   logic              prd_start_q;
   logic              prd_start_d;
   logic              wrap;

   logic [NUM_CH-1:0] hi_w;
   logic [NUM_CH-1:0] lo_w;
   logic [NUM_CH-1:0] at_w;

   // The counter keeps running while disabled so channels stay phase-aligned.
   always_comb begin
      wrap        = (cnt_q == {SPD_W{1'b1}});
      cnt_d       = cnt_q + SPD_W'(1);
      prd_start_d = wrap;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         prd_start_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         prd_start_q <= prd_start_d;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      mtr_pwm_ch #(
         .SPD_W     (SPD_W),
         .DEADTIME  (DEADTIME),
         .SLEW_STEP (SLEW_STEP)
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .cnt    (cnt_q),
         .wrap   (wrap),
         .en     (bus.en),
         .spd    (bus.spd[i*SPD_W +: SPD_W]),
         .pwm_hi (hi_w[i]),
         .pwm_lo (lo_w[i]),
         .at_tgt (at_w[i])
      );
   end

   assign bus.pwm_hi    = hi_w;
   assign bus.pwm_lo    = lo_w;
   assign bus.at_tgt    = at_w;
   assign bus.prd_start = prd_start_q;

endmodule
